maze_explorer: RTL and testbench



---
 rtl/maze_pkg.sv | 63 ++++++
 rtl/maze_explorer_dir_stack.sv | 64 ++++++
 rtl/maze_explorer.sv | 242 ++++++++++++++++++++++++
 tb/tb_maze_explorer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared types, direction encodings and move helpers for the
//                maze explorer.
//  Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

  localparam int GRID = 16;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_MARK = 4'd1,
    ST_PICK = 4'd2,
    ST_READ = 4'd3,
    ST_EVAL = 4'd4,
    ST_POP  = 4'd5,
    ST_DUMP = 4'd6,
    ST_DONE = 4'd7,
    ST_FAIL = 4'd8
  } state_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  // True when a step in direction d stays inside the grid (no wrap-around).
  function automatic logic can_move(input logic [3:0] x, input logic [3:0] y,
                                    input logic [1:0] d);
    logic ok;
    case (d)
      DIR_UP:    ok = (y != 4'd0);
      DIR_RIGHT: ok = (x != 4'(GRID - 1));
      DIR_DOWN:  ok = (y != 4'(GRID - 1));
      default:   ok = (x != 4'd0);
    endcase
    return ok;
  endfunction

  // Returns {x, y} after one step in direction d.
  function automatic logic [7:0] move(input logic [3:0] x, input logic [3:0] y,
                                      input logic [1:0] d);
    logic [3:0] nx;
    logic [3:0] ny;
    nx = x;
    ny = y;
    case (d)
      DIR_UP:    ny = y - 4'd1;
      DIR_RIGHT: nx = x + 4'd1;
      DIR_DOWN:  ny = y + 4'd1;
      default:   nx = x - 4'd1;
    endcase
    return {nx, ny};
  endfunction

endpackage
`default_nettype wire

// File: rtl/maze_explorer_dir_stack.sv
`default_nettype none
// ============================================================================
//  Module      : dir_stack
//  Description : Synchronous 2-bit LIFO of move directions. The indexed read
//                port exists only when PATH_DUMP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module dir_stack #(
  parameter int STACK_DEPTH = 256,
  parameter int PTR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [1:0]       push_data,
  output logic [1:0]       top,
  output logic [PTR_W:0]   sp,
  output logic             empty
`ifdef PATH_DUMP_EN
  ,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [1:0]       rd_data
`endif
);

  localparam logic [PTR_W:0] c_one = (PTR_W + 1)'(1);

  logic [1:0]       r_mem [STACK_DEPTH];
  logic [PTR_W:0]   r_sp;
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx = PTR_W'(r_sp - c_one);
  assign top       = r_mem[w_top_idx];
  assign sp        = r_sp;
  assign empty     = (r_sp == '0);

`ifdef PATH_DUMP_EN
  assign rd_data = r_mem[rd_idx];
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_sp <= '0;
    end else if (push) begin
      r_sp <= r_sp + c_one;
    end else if (pop) begin
      r_sp <= r_sp - c_one;
    end
  end

  // Storage is left unreset; only the pointer defines valid contents.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) begin
      r_mem[r_sp[PTR_W-1:0]] <= push_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   push |-> (r_sp < STACK_DEPTH));

endmodule
`default_nettype wire

// File: rtl/maze_explorer.sv
`default_nettype none
// ============================================================================
//  Module      : maze_explorer
//  Description : Depth-first solver driving the 16x16 maze bitmap memory.
//                Optional macro PATH_DUMP_EN streams the solved path out.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_explorer
  import maze_pkg::*;
#(
  parameter int GOAL_X      = 15,
  parameter int GOAL_Y      = 15,
  parameter int STACK_DEPTH = 256,
  parameter int PTR_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           rd,
  output logic           wr,
  output logic [3:0]     x_pos,
  output logic [3:0]     y_pos,
  output logic           wr_data,
  input  logic           rd_data,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic [PTR_W:0] path_len
`ifdef PATH_DUMP_EN
  ,
  output logic [1:0]     dir_out,
  output logic           dir_valid
`endif
);

  localparam logic [3:0] c_goal_x = 4'(GOAL_X);
  localparam logic [3:0] c_goal_y = 4'(GOAL_Y);

  state_t         r_state, w_state_n;
  logic [3:0]     r_cur_x, r_cur_y, w_cur_x, w_cur_y;
  logic [3:0]     r_nxt_x, r_nxt_y, w_nxt_x, w_nxt_y;
  logic [2:0]     r_cand, w_cand;
  logic           r_rd, r_wr, r_wr_data;
  logic [3:0]     r_x_pos, r_y_pos;
  logic           r_busy, r_done, r_fail;
  logic [PTR_W:0] r_path_len;

  logic           w_push, w_pop, w_clear;
  logic [1:0]     w_top;
  logic [PTR_W:0] w_sp;
  logic           w_empty;
  logic [7:0]     w_fwd, w_back;

`ifdef PATH_DUMP_EN
  localparam logic [PTR_W:0] c_one = (PTR_W + 1)'(1);
  logic [PTR_W-1:0] r_dump_idx, w_dump_idx;
  logic [1:0]       w_dump_dir;
`endif

  dir_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .PTR_W      (PTR_W)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .push     (w_push),
    .pop      (w_pop),
    .push_data(r_cand[1:0]),
    .top      (w_top),
    .sp       (w_sp),
    .empty    (w_empty)
`ifdef PATH_DUMP_EN
    ,
    .rd_idx   (r_dump_idx),
    .rd_data  (w_dump_dir)
`endif
  );

  assign w_fwd  = move(r_cur_x, r_cur_y, r_cand[1:0]);
  assign w_back = move(r_cur_x, r_cur_y, opposite(w_top));

  always_comb begin
    w_state_n = r_state;
    w_cur_x   = r_cur_x;
    w_cur_y   = r_cur_y;
    w_nxt_x   = r_nxt_x;
    w_nxt_y   = r_nxt_y;
    w_cand    = r_cand;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clear   = 1'b0;
`ifdef PATH_DUMP_EN
    w_dump_idx = r_dump_idx;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear   = 1'b1;
          w_cur_x   = 4'd0;
          w_cur_y   = 4'd0;
          w_cand    = 3'd0;
          w_state_n = ST_MARK;
        end
      end
      ST_MARK: w_state_n = ST_PICK;
      ST_PICK: begin
        if (r_cur_x == c_goal_x && r_cur_y == c_goal_y) begin
`ifdef PATH_DUMP_EN
          w_dump_idx = '0;
          w_state_n  = w_empty ? ST_DONE : ST_DUMP;
`else
          w_state_n = ST_DONE;
`endif
        end else if (r_cand == 3'd4) begin
          w_state_n = ST_POP;
        end else if (!can_move(r_cur_x, r_cur_y, r_cand[1:0])) begin
          w_cand = r_cand + 3'd1;
        end else begin
          w_nxt_x   = w_fwd[7:4];
          w_nxt_y   = w_fwd[3:0];
          w_state_n = ST_READ;
        end
      end
      ST_READ: w_state_n = ST_EVAL;
      ST_EVAL: begin
        if (rd_data) begin
          w_cand    = r_cand + 3'd1;
          w_state_n = ST_PICK;
        end else begin
          w_push    = 1'b1;
          w_cur_x   = r_nxt_x;
          w_cur_y   = r_nxt_y;
          w_cand    = 3'd0;
          w_state_n = ST_MARK;
        end
      end
      ST_POP: begin
        if (w_empty) begin
          w_state_n = ST_FAIL;
        end else begin
          // Step back along the reverse of the popped move, resume after it.
          w_pop     = 1'b1;
          w_cur_x   = w_back[7:4];
          w_cur_y   = w_back[3:0];
          w_cand    = {1'b0, w_top} + 3'd1;
          w_state_n = ST_PICK;
        end
      end
`ifdef PATH_DUMP_EN
      ST_DUMP: begin
        w_dump_idx = r_dump_idx + 1'b1;
        if (({1'b0, r_dump_idx} + c_one) == w_sp) begin
          w_state_n = ST_DONE;
        end
      end
`endif
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur_x    <= 4'd0;
      r_cur_y    <= 4'd0;
      r_nxt_x    <= 4'd0;
      r_nxt_y    <= 4'd0;
      r_cand     <= 3'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_wr_data  <= 1'b0;
      r_x_pos    <= 4'd0;
      r_y_pos    <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_path_len <= '0;
    end else begin
      r_state   <= w_state_n;
      r_cur_x   <= w_cur_x;
      r_cur_y   <= w_cur_y;
      r_nxt_x   <= w_nxt_x;
      r_nxt_y   <= w_nxt_y;
      r_cand    <= w_cand;
      // Strobes and address are derived from the next state so they are
      // registered yet line up with the READ / MARK cycles.
      r_rd      <= (w_state_n == ST_READ);
      r_wr      <= (w_state_n == ST_MARK);
      r_wr_data <= (w_state_n == ST_MARK);
      if (w_state_n == ST_READ) begin
        r_x_pos <= w_nxt_x;
        r_y_pos <= w_nxt_y;
      end else if (w_state_n == ST_MARK) begin
        r_x_pos <= w_cur_x;
        r_y_pos <= w_cur_y;
      end
      if (r_state == ST_IDLE && start) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_fail <= 1'b0;
      end
      if (r_state == ST_DONE) begin
        r_done     <= 1'b1;
        r_busy     <= 1'b0;
        r_path_len <= w_sp;
      end
      if (r_state == ST_FAIL) begin
        r_fail     <= 1'b1;
        r_busy     <= 1'b0;
        r_path_len <= w_sp;
      end
    end
  end

`ifdef PATH_DUMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_idx <= '0;
    end else begin
      r_dump_idx <= w_dump_idx;
    end
  end

  assign dir_out   = w_dump_dir;
  assign dir_valid = (r_state == ST_DUMP);
`endif

  assign rd       = r_rd;
  assign wr       = r_wr;
  assign wr_data  = r_wr_data;
  assign x_pos    = r_x_pos;
  assign y_pos    = r_y_pos;
  assign busy     = r_busy;
  assign done     = r_done;
  assign fail     = r_fail;
  assign path_len = r_path_len;

  a_no_rd_wr : assert property (@(posedge clk) disable iff (rst) !(r_rd && r_wr));

endmodule
`default_nettype wire

// File: tb/tb_maze_explorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_explorer
//  Description : Directed self-checking bench for maze_explorer with a
//                behavioural 16x16 bitmap memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_maze_explorer;

  localparam int PTR_W = 8;

`ifdef PATH_DUMP_EN
  localparam int c_dump_extra = 30;
`else
  localparam int c_dump_extra = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           rd, wr, wr_data, busy, done, fail;
  logic           rd_data = 1'b0;
  logic [3:0]     x_pos, y_pos;
  logic [PTR_W:0] path_len;
`ifdef PATH_DUMP_EN
  logic [1:0]     dir_out;
  logic           dir_valid;
  int             dump_cnt = 0;
  int             dump_bad = 0;
`endif

  always #5 clk = ~clk;

  maze_explorer #(
    .GOAL_X(15), .GOAL_Y(15), .STACK_DEPTH(256), .PTR_W(PTR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd(rd), .wr(wr),
    .x_pos(x_pos), .y_pos(y_pos), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .done(done), .fail(fail), .path_len(path_len)
`ifdef PATH_DUMP_EN
    , .dir_out(dir_out), .dir_valid(dir_valid)
`endif
  );

  logic       mem [256];
  int         load_map = 0;
  logic       load_req = 1'b0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_wr = 8'd0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Map 0: all free. Map 1: walls at (1,0),(0,1). Map 2: dead end at (1,0),
  // real route down column 0 then along row 15.
  function automatic logic map_bit(input int m, input int x, input int y);
    case (m)
      1:       return (x == 1 && y == 0) || (x == 0 && y == 1);
      2:       return !((y == 0 && x <= 1) || x == 0 || y == 15);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= map_bit(load_map, i % 16, i / 16);
    end else begin
      if (rd) begin
        rd_data <= mem[{y_pos, x_pos}];
        rd_cnt  <= rd_cnt + 1;
      end
      if (wr) begin
        mem[{y_pos, x_pos}] <= wr_data;
        wr_cnt  <= wr_cnt + 1;
        last_wr <= {y_pos, x_pos};
      end
      if (rd && wr) both_cnt <= both_cnt + 1;
    end
`ifdef PATH_DUMP_EN
    if (start && !busy && !rst) begin
      dump_cnt <= 0;
      dump_bad <= 0;
    end else if (dir_valid) begin
      dump_cnt <= dump_cnt + 1;
      if (dir_out != ((dump_cnt < 15) ? 2'd1 : 2'd2)) dump_bad <= dump_bad + 1;
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int m);
    @(negedge clk);
    load_map = m;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts clock edges after the accepting edge until done or fail is seen.
  task automatic wait_end(input bit poke, output int cyc);
    cyc = 0;
    while (!(done || fail) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = poke && !(done || fail) && (cyc % 17 == 5);
    end
    start = 1'b0;
    if (!(done || fail)) check("timeout", 32'd0, 32'd1);
  endtask

  int r0, w0, cyc, k;

  initial begin
    load(0);
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({rd, wr, x_pos, y_pos, wr_data, busy, done, fail, path_len}), 32'd0);
    rst = 1'b0;

    // All-free map
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_start();
    check("free_busy", 32'(busy), 32'd1);
    wait_end(1'b0, cyc);
    check("free_done", 32'(done), 32'd1);
    check("free_fail", 32'(fail), 32'd0);
    check("free_len", 32'(path_len), 32'd30);
    check("free_rds", 32'(rd_cnt - r0), 32'd44);
    check("free_wrs", 32'(wr_cnt - w0), 32'd31);
    check("free_cycles", 32'(cyc), 32'(196 + c_dump_extra));
    check("free_goal_marked", 32'(mem[255]), 32'd1);
    check("free_row0_marked", 32'(mem[14]), 32'd1);
    check("free_unvisited", 32'(mem[240]), 32'd0);
    check("free_busy_end", 32'(busy), 32'd0);
`ifdef PATH_DUMP_EN
    check("dump_beats", 32'(dump_cnt), 32'd30);
    check("dump_seq_bad", 32'(dump_bad), 32'd0);
`endif

    // Boxed-in start cell
    load(1);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_start();
    check("wall_done_cleared", 32'(done), 32'd0);
    wait_end(1'b0, cyc);
    check("wall_fail", 32'(fail), 32'd1);
    check("wall_done", 32'(done), 32'd0);
    check("wall_len", 32'(path_len), 32'd0);
    check("wall_rds", 32'(rd_cnt - r0), 32'd2);
    check("wall_wrs", 32'(wr_cnt - w0), 32'd1);
    check("wall_wr_addr", 32'(last_wr), 32'd0);
    check("wall_cycles", 32'(cyc), 32'd12);

    // Dead-end corridor with one backtrack
    load(2);
    r0 = rd_cnt; w0 = wr_cnt;
    pulse_start();
    wait_end(1'b0, cyc);
    check("corr_done", 32'(done), 32'd1);
    check("corr_len", 32'(path_len), 32'd30);
    check("corr_rds", 32'(rd_cnt - r0), 32'd77);
    check("corr_wrs", 32'(wr_cnt - w0), 32'd32);
    check("corr_deadend_marked", 32'(mem[1]), 32'd1);
    check("corr_col0_marked", 32'(mem[112]), 32'd1);
    check("corr_corner_marked", 32'(mem[240]), 32'd1);

    // Reset while a read is in flight
    load(0);
    pulse_start();
    k = 0;
    while (!rd && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_saw_read", 32'(rd), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outs", 32'({rd, wr, x_pos, y_pos, wr_data, busy, done, fail, path_len}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load(0);
    pulse_start();
    wait_end(1'b0, cyc);
    check("rst_resolve_done", 32'(done), 32'd1);
    check("rst_resolve_len", 32'(path_len), 32'd30);

    // Repeated start while busy must not disturb the walk
    load(0);
    r0 = rd_cnt;
    pulse_start();
    wait_end(1'b1, cyc);
    check("poke_cycles", 32'(cyc), 32'(196 + c_dump_extra));
    check("poke_rds", 32'(rd_cnt - r0), 32'd44);
    check("poke_len", 32'(path_len), 32'd30);

    // start coincident with rst is dropped
    w0 = wr_cnt;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_done", 32'(done), 32'd0);
    check("rst_start_wrs", 32'(wr_cnt - w0), 32'd0);
    check("no_rd_wr_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
